// File: rtl/delay_bf_pkg.sv
// Shared definitions for the delay-and-sum tap scheduler.
package delay_bf_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int IDX_W_DEF  = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/delay_tap_table.sv
// Delay-index table: simple dual-port RAM, one write port, one registered read port.
// Contents are not reset; the host loads the table before each use.
module delay_tap_table
  import delay_bf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [IDX_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [IDX_W-1:0]  rd_data_o
);

  logic [IDX_W-1:0] mem_q [2**ADDR_W];
  logic [IDX_W-1:0] rd_data_q;

  // Write port and 1-cycle-latency read port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/delay_tap_scheduler.sv
// Walks the delay-index table against the incoming sample-index stream and
// emits each matching sample tagged with its tap number.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | host may write the table; waits for start
// PRIME | two cycles: read tap 0 into the head register, then tap 1 into RAM out
// RUN   | compare in_index against the head entry on every valid sample
// DONE  | frame over (last tap matched, miss, or cfg_len==0); back to IDLE
//
// The prefetch is two entries deep: cur_q holds table[ptr] and the RAM read
// register holds table[ptr+1]. On a match the read address already points
// two ahead, so a match can be sustained on every consecutive cycle.
module delay_tap_scheduler
  import delay_bf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [IDX_W-1:0]  cfg_data,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_value,
  output logic [ADDR_W-1:0] out_tap,
  output logic              busy,
  output logic              done,
  output logic              err_missed,
  output logic              cfg_reject
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic              prime_q, prime_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [ADDR_W-1:0] out_tap_q, out_tap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rej_q, rej_d;

  logic              tbl_wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  rd_data;
  logic              hit;
  logic              miss;
  logic              last_tap;

  // Host writes only land while the scheduler is idle.
  assign tbl_wr_en = cfg_wr_en && (state_q == ST_IDLE);

  delay_tap_table #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk       (clk),
    .wr_en_i   (tbl_wr_en),
    .wr_addr_i (cfg_addr),
    .wr_data_i (cfg_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign hit      = (state_q == ST_RUN) && in_valid && (in_index == cur_q);
  assign miss     = (state_q == ST_RUN) && in_valid && (in_index > cur_q);
  assign last_tap = ({1'b0, ptr_q} == (len_q - LEN_ONE));

  // State and datapath registers; every output is driven from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      cur_q       <= '0;
      prime_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_tap_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cur_q       <= cur_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_tap_q   <= out_tap_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rej_q       <= rej_d;
    end
  end

  // Next-state, prefetch address and output decisions.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cur_d       = cur_q;
    prime_d     = prime_q;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    out_tap_d   = out_tap_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rej_d       = rej_q;
    rd_addr     = '0;

    if (cfg_wr_en && (state_q != ST_IDLE)) begin
      rej_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          len_d   = cfg_len;
          ptr_d   = '0;
          prime_d = 1'b0;
          err_d   = 1'b0;
          rej_d   = 1'b0;
          if (cfg_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PRIME;
          end
        end
      end

      ST_PRIME: begin
        // First cycle reads tap 0; second latches it and reads tap 1.
        if (prime_q) begin
          cur_d   = rd_data;
          rd_addr = ptr_q + PTR_ONE;
          prime_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          rd_addr = ptr_q;
          prime_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (hit) begin
          out_valid_d = 1'b1;
          out_value_d = in_value;
          out_tap_d   = ptr_q;
          if (last_tap) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
            cur_d = rd_data;
          end
        end else if (miss) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        // Keep the RAM output one entry ahead of the head register.
        rd_addr = ptr_d + PTR_ONE;
      end

      ST_DONE: begin
        // A miss or empty frame already pulsed done on entry.
        done_d  = !done_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign out_tap    = out_tap_q;
  assign busy       = (state_q == ST_PRIME) || (state_q == ST_RUN);
  assign done       = done_q;
  assign err_missed = err_q;
  assign cfg_reject = rej_q;

endmodule
